// File: rtl/demux_buf_pkg.sv
// Shared types and constants for the buffered 1-to-2 demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    LANE_EMPTY,
    LANE_ONE,
    LANE_TWO
  } lane_state_e;

  localparam int DEMUX_MAX_DEFAULT = 31;
  localparam int DEMUX_CNT_W       = 16;

endpackage

// File: rtl/demux_buf_if.sv
// Producer stream plus two consumer lanes of the demultiplexer, bundled as one interface.
interface demux_buf_if #(
  parameter int max = 31
);

  logic [max:0] in_data;
  logic         in_select;
  logic         in_valid;
  logic         in_ready;
  logic [max:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [max:0] out2_data;
  logic         out2_valid;
  logic         out2_ready;

  // Demultiplexer side: accepts the producer stream, drives both lanes.
  modport slave (
    input  in_data, in_select, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid
  );

  // Producer/consumer side.
  modport master (
    output in_data, in_select, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid
  );

endinterface

// File: rtl/demux_lane.sv
// One output lane: main register plus skid slot with an EMPTY/ONE/TWO state machine.
// With DEMUX_STATS_EN defined, a wrapping pop counter is added.
module demux_lane
  import demux_pkg::*;
#(
  parameter int max = DEMUX_MAX_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [max:0]           word,
  input  logic                   take,
  output logic                   valid,
  output logic [max:0]           data,
  output logic                   full
`ifdef DEMUX_STATS_EN
  ,
  output logic [DEMUX_CNT_W-1:0] count
`endif
);

  lane_state_e  state_q, state_d;
  logic [max:0] main_q, skid_q;
  logic         load_main, load_skid, shift;
  logic         pop;

  assign valid = (state_q != LANE_EMPTY);
  assign full  = (state_q == LANE_TWO);
  assign data  = main_q;
  assign pop   = valid && take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LANE_EMPTY;
    else        state_q <= state_d;
  end

  // A push never arrives in TWO because the top holds in_ready low then.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    case (state_q)
      LANE_EMPTY: begin
        if (push) begin
          state_d   = LANE_ONE;
          load_main = 1'b1;
        end
      end
      LANE_ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          state_d   = LANE_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d   = LANE_EMPTY;
        end
      end
      LANE_TWO: begin
        if (pop) begin
          state_d = LANE_ONE;
          shift   = 1'b1;
        end
      end
      default: state_d = LANE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)  main_q <= word;
      else if (shift) main_q <= skid_q;
      if (load_skid)  skid_q <= word;
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (pop) count <= count + DEMUX_CNT_W'(1);
  end
`endif

endmodule

// File: rtl/demux_buf.sv
// Buffered 1-to-2 demultiplexer: steers each producer word to lane 1 or 2 by select.
// Optional per-lane pop counters when DEMUX_STATS_EN is defined.
module demux_buf
  import demux_pkg::*;
#(
  parameter int max = DEMUX_MAX_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_buf_if.slave             bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [DEMUX_CNT_W-1:0] count1,
  output logic [DEMUX_CNT_W-1:0] count2
`endif
);

  logic full1, full2;
  logic ready;
  logic push1, push2;

  // Ready comes only from registered lane state; a full lane stalls both lanes.
  assign ready        = !(full1 || full2);
  assign bus.in_ready = ready;
  assign push1        = bus.in_valid && ready && !bus.in_select;
  assign push2        = bus.in_valid && ready &&  bus.in_select;

  demux_lane #(.max(max)) u_lane1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .word  (bus.in_data),
    .take  (bus.out1_ready),
    .valid (bus.out1_valid),
    .data  (bus.out1_data),
    .full  (full1)
`ifdef DEMUX_STATS_EN
    ,
    .count (count1)
`endif
  );

  demux_lane #(.max(max)) u_lane2 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push2),
    .word  (bus.in_data),
    .take  (bus.out2_ready),
    .valid (bus.out2_valid),
    .data  (bus.out2_data),
    .full  (full2)
`ifdef DEMUX_STATS_EN
    ,
    .count (count2)
`endif
  );

endmodule

// File: tb/tb_demux_buf.sv
// Self-checking bench for demux_buf: queue-based lane model plus directed literal checks.
module tb_demux_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  demux_buf_if #(.max(31)) bus ();

`ifdef DEMUX_STATS_EN
  logic [15:0] count1, count2;
  demux_buf #(.max(31)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .count1(count1), .count2(count2));
`else
  demux_buf #(.max(31)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Model: each lane is a FIFO of at most two words; the producer is accepted
  // only while neither FIFO holds two words.
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [15:0] m_cnt1 = '0;
  logic [15:0] m_cnt2 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      m_cnt1 = '0;
      m_cnt2 = '0;
    end else begin
      bit rdy, pop1, pop2;
      rdy  = (q1.size() < 2) && (q2.size() < 2);
      pop1 = (q1.size() > 0) && bus.out1_ready;
      pop2 = (q2.size() > 0) && bus.out2_ready;
      if (pop1) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + 16'd1; end
      if (pop2) begin void'(q2.pop_front()); m_cnt2 = m_cnt2 + 16'd1; end
      if (bus.in_valid && rdy) begin
        if (bus.in_select) q2.push_back(bus.in_data);
        else               q1.push_back(bus.in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
      chk("model_out2_valid", 32'(bus.out2_valid), 32'(q2.size() != 0));
      chk("model_in_ready", 32'(bus.in_ready), 32'((q1.size() < 2) && (q2.size() < 2)));
      if (q1.size() != 0) chk("model_out1_data", bus.out1_data, q1[0]);
      if (q2.size() != 0) chk("model_out2_data", bus.out2_data, q2[0]);
`ifdef DEMUX_STATS_EN
      chk("model_count1", 32'(count1), 32'(m_cnt1));
      chk("model_count2", 32'(count2), 32'(m_cnt2));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_select  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;

    // Power-on reset state
    #2;
    chk("por_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("por_out2_valid", 32'(bus.out2_valid), 32'd0);
    chk("por_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    rst_n = 1'b1;

    // Fill lane 1 to TWO with 0xDEADBEEF, then reset mid-operation
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("two_in_ready", 32'(bus.in_ready), 32'd0);
    chk("two_out1_data", bus.out1_data, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("rst_out2_valid", 32'(bus.out2_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out1_data", bus.out1_data, 32'd0);
`ifdef DEMUX_STATS_EN
    chk("rst_count1", 32'(count1), 32'd0);
    chk("rst_count2", 32'(count2), 32'd0);
`endif
    cyc();
    rst_n = 1'b1;

    // Streaming pass-through on lane 1
    bus.out1_ready = 1'b1;
    bus.in_select  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'h11;
    cyc();
    bus.in_data = 32'h22;
    @(negedge clk);
    chk("stream_d0", bus.out1_data, 32'h11);
    chk("stream_v2", 32'(bus.out2_valid), 32'd0);
    cyc();
    bus.in_data = 32'h33;
    @(negedge clk);
    chk("stream_d1", bus.out1_data, 32'h22);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_d2", bus.out1_data, 32'h33);
    chk("stream_v2b", 32'(bus.out2_valid), 32'd0);

    // Lane 2 stalls into TWO, then drains in order
    bus.out2_ready = 1'b0;
    bus.in_select  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hA;
    cyc();
    bus.in_data = 32'hB;
    @(negedge clk);
    chk("stall_d_a", bus.out2_data, 32'hA);
    chk("stall_rdy1", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stall_rdy0", 32'(bus.in_ready), 32'd0);
    chk("stall_hold_a", bus.out2_data, 32'hA);
    bus.out2_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("drain_d_b", bus.out2_data, 32'hB);
    chk("drain_rdy", 32'(bus.in_ready), 32'd1);
    cyc();
    @(negedge clk);
    chk("drain_v2", 32'(bus.out2_valid), 32'd0);

    // Full lane 1 holds off a push destined for lane 2
    bus.out1_ready = 1'b0;
    bus.in_select  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'h1;
    cyc();
    bus.in_data = 32'h2;
    cyc();
    bus.in_select = 1'b1;
    bus.in_data   = 32'h77;
    @(negedge clk);
    chk("block_rdy", 32'(bus.in_ready), 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    chk("block_v2", 32'(bus.out2_valid), 32'd0);
    chk("block_d1", bus.out1_data, 32'h1);
    bus.out1_ready = 1'b1;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("unblock_v2", 32'(bus.out2_valid), 32'd1);
    chk("unblock_d2", bus.out2_data, 32'h77);
    chk("unblock_v1", 32'(bus.out1_valid), 32'd0);
    cyc();

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_select  = 1'($urandom_range(0, 1));
      bus.in_data    = $urandom;
      bus.out1_ready = ($urandom_range(0, 3) != 0);
      bus.out2_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc();

`ifdef DEMUX_STATS_EN
    // 65536 pops on lane 1 wrap its counter back to zero
    #1 rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.out1_ready = 1'b1;
    bus.in_select  = 1'b0;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      bus.in_data = 32'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("wrap_count1", 32'(count1), 32'd0);
    chk("wrap_count2", 32'(count2), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_buf.md
# demux_buf

Buffered 1-to-2 demultiplexer with valid/ready handshake: one producer stream is steered per word by a select bit to one of two consumer lanes. Each lane has a registered output stage plus a skid slot, so a stalled consumer never corrupts data and the producer sees a registered ready. It sits between the core's result source and two downstream consumers, and is the steering counterpart of the core's 2:1 `mux`.

## Interface
Parameters:
- `max`, 31: MSB index of the data path; data width is `max+1`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `[max:0]`  producer word.
- `in_select`  in  1  lane select; 0 routes to lane 1, 1 routes to lane 2. Sampled with `in_data`.
- `in_valid`  in  1  producer word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `out1_data`  out  `[max:0]`  lane 1 word.
- `out1_valid`  out  1  lane 1 word present.
- `out1_ready`  in  1  lane 1 consumer accepts.
- `out2_data`, `out2_valid`, `out2_ready`: same as lane 1, for lane 2.
- `count1`, `count2`  out  16  only with `DEMUX_STATS_EN`; see Configuration.

## Operation
- Push: `in_valid && in_ready`. The word goes to the lane named by `in_select`.
- Pop on lane N: `outN_valid && outN_ready`.
- Each lane is a state machine with a main register and a skid register. States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - TWO: main and skid both valid.
- Lane transitions (push means push to this lane):
  - EMPTY + push -> ONE. Main takes the word.
  - ONE + push + pop -> ONE. Main takes the new word.
  - ONE + push, no pop -> TWO. Skid takes the word.
  - ONE + pop, no push -> EMPTY.
  - TWO + pop -> ONE. Skid moves to main.
  - TWO + push cannot occur, because `in_ready` is low.
- `in_ready` = neither lane is in TWO. It depends only on registered state, with no combinational path from any `*_ready`.
- A full lane also stalls pushes destined for the other lane. This is an accepted throughput limit.
- Ordering is preserved within each lane. No ordering is defined between lanes.
- `outN_valid` = lane N state is not EMPTY.
- `outN_data` = lane N main register. Its value is don't-care while `outN_valid` is 0.
- Consumers may hold `outN_ready` high indefinitely. Data and valid must stay stable while valid is high and ready is low.

## Timing
- Latency: a word pushed in cycle t appears on `outN_valid`/`outN_data` in cycle t+1.
- Throughput: one word per cycle sustained while the consumer keeps ready high.
- Reset (asynchronous assert, release on the next edge):
  - both lanes go to EMPTY;
  - `out1_valid` = `out2_valid` = 0 and `in_ready` = 1;
  - data registers are cleared to 0;
  - counters are cleared to 0.
- Reset mid-operation drops all buffered words. No partial transfer completes.
- Simultaneous push and pop on the same lane in state ONE gives a full pass-through with no bubble.
- Push to lane 1 and pop on lane 2 in the same cycle are independent.

## Configuration
- `DEMUX_STATS_EN` defined:
  - `count1` and `count2` exist;
  - each is a 16-bit counter incremented on every pop of its lane;
  - it wraps from 0xFFFF to 0x0000;
  - reset value is 0.
- `DEMUX_STATS_EN` undefined: the ports and counters are absent, and datapath behaviour is identical.

## Structure
- Package `demux_pkg`:
  - lane state enum `{LANE_EMPTY, LANE_ONE, LANE_TWO}`;
  - `DEMUX_MAX_DEFAULT` = 31;
  - `DEMUX_CNT_W` = 16.
- Sub-module `demux_lane`: one lane with its state machine, main and skid registers, and optional counter. It is instantiated twice.
- The top module holds only select decode and the `in_ready` logic.

## Test plan
- Reset while lane 1 holds 0xDEADBEEF in TWO -> next cycle both valids 0, `in_ready`=1, counters 0.
- Push 0x11, 0x22, 0x33 with select 0 on consecutive cycles, `out1_ready`=1 -> `out1_data` is 0x11, 0x22, 0x33 on cycles t+1..t+3; `out2_valid` stays 0.
- `out2_ready`=0 and push 0xA, 0xB with select 1 -> lane 2 goes to TWO and `in_ready`=0. Raise `out2_ready` -> 0xA then 0xB pop in order, and `in_ready` returns to 1 after the first pop.
- Lane 1 in TWO while pushing to lane 2 -> the push is held off until lane 1 pops. No word is lost or duplicated.
- Random select, valid and ready over 10k cycles against a per-lane scoreboard -> exact per-lane order. With `DEMUX_STATS_EN`, count1 + count2 equals total pops modulo 2^16.
- With `DEMUX_STATS_EN`, 65536 pops on lane 1 -> `count1` wraps to 0x0000.
